// File: rtl/add_tree_pipelined.sv
// Pipelined adder tree: registers the operands, then reduces them pairwise with one register per
// level. The result is exact at OUT_WIDTH, and the whole pipeline stalls while en is low.
module add_tree_pipelined #(
  parameter int unsigned NUM_INPUTS = 8,
  parameter int unsigned WIDTH      = 16,
  parameter int          SIGNED     = 0,
  localparam int unsigned LEVELS    = $clog2(NUM_INPUTS),
  localparam int unsigned OUT_WIDTH = WIDTH + LEVELS,
  localparam int unsigned LATENCY   = LEVELS + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 valid_in,
  input  logic [WIDTH-1:0]     inputs [NUM_INPUTS],
  output logic [OUT_WIDTH-1:0] result,
  output logic                 valid_out
);

  // Number of nodes held in the register of tree level lvl (level 0 = operand register).
  function automatic int unsigned lvl_cnt(int unsigned lvl);
    int unsigned c;
    c = NUM_INPUTS;
    for (int unsigned l = 0; l < lvl; l++) c = (c + 1) / 2;
    return c;
  endfunction

  function automatic int unsigned lvl_off(int unsigned lvl);
    int unsigned o;
    o = 0;
    for (int unsigned l = 0; l < lvl; l++) o += lvl_cnt(l);
    return o;
  endfunction

  // All tree nodes live in one flat array, level after level; the last entry is the root.
  localparam int unsigned TOTAL = lvl_off(LEVELS + 1);

  logic [OUT_WIDTH-1:0] r_node [TOTAL];
  logic [OUT_WIDTH-1:0] w_next [TOTAL];
  logic [LATENCY-1:0]   r_valid;

  for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_ext
    if (SIGNED != 0) begin : g_sext
      assign w_next[i] = {{LEVELS{inputs[i][WIDTH-1]}}, inputs[i]};
    end else begin : g_zext
      assign w_next[i] = {{LEVELS{1'b0}}, inputs[i]};
    end
  end

  for (genvar j = 1; j <= LEVELS; j++) begin : g_lvl
    localparam int unsigned Cnt     = lvl_cnt(j);
    localparam int unsigned Off     = lvl_off(j);
    localparam int unsigned PrevCnt = lvl_cnt(j - 1);
    localparam int unsigned PrevOff = lvl_off(j - 1);
    for (genvar k = 0; k < Cnt; k++) begin : g_node
      if (2 * k + 1 < PrevCnt) begin : g_add
        assign w_next[Off+k] = r_node[PrevOff+2*k] + r_node[PrevOff+2*k+1];
      end else begin : g_pass
        // Odd operand left over at this level rides through unchanged.
        assign w_next[Off+k] = r_node[PrevOff+2*k];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int n = 0; n < TOTAL; n++) r_node[n] <= '0;
      r_valid <= '0;
    end else if (en) begin
      for (int n = 0; n < TOTAL; n++) r_node[n] <= w_next[n];
      r_valid <= {r_valid[LATENCY-2:0], valid_in};
    end
  end

  assign result    = r_node[TOTAL-1];
  assign valid_out = r_valid[LATENCY-1];

endmodule

// File: tb/tb_add_tree_pipelined.sv
// Scoreboard bench: three configurations (8x16 unsigned, 8x16 signed, 5x8 unsigned) share one
// randomized stimulus stream; expected sums come from plain integer arithmetic.
module tb_add_tree_pipelined;
  localparam int LEV = 3;

  logic        clk = 1'b0;
  logic        rst, en, vin;
  logic [15:0] din  [8];
  logic [7:0]  din5 [5];
  logic [18:0] res_u, res_s;
  logic [10:0] res_5;
  logic        vo_u, vo_s, vo_5;

  for (genvar i = 0; i < 5; i++) begin : g_d5
    assign din5[i] = din[i][7:0];
  end

  always #5 clk = ~clk;

  add_tree_pipelined u_dut_u (
    .clk(clk), .rst(rst), .en(en), .valid_in(vin), .inputs(din),
    .result(res_u), .valid_out(vo_u)
  );

  add_tree_pipelined #(.SIGNED(1)) u_dut_s (
    .clk(clk), .rst(rst), .en(en), .valid_in(vin), .inputs(din),
    .result(res_s), .valid_out(vo_s)
  );

  add_tree_pipelined #(.NUM_INPUTS(5), .WIDTH(8)) u_dut_5 (
    .clk(clk), .rst(rst), .en(en), .valid_in(vin), .inputs(din5),
    .result(res_5), .valid_out(vo_5)
  );

  typedef struct {
    longint val;
    int     stamp;
  } exp_t;

  exp_t   q [3][$];
  int     n_checks = 0;
  int     n_fail = 0;
  int     en_cnt = 0;
  bit     last_stall = 0;
  bit     last_rst = 0;
  bit     mon_on = 0;
  bit     pv [3];
  longint pr [3];

  task automatic chk(input string name, input int id, input bit ok, input longint act,
                     input longint exp);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s dut%0d: got 0x%0h expected 0x%0h at %0t", name, id, act, exp, $time);
    end
  endtask

  function automatic longint model(input int id);
    longint s;
    s = 0;
    case (id)
      0: begin
        for (int i = 0; i < 8; i++) s += longint'(din[i]);
        s = s & ((64'sd1 <<< 19) - 1);
      end
      1: begin
        for (int i = 0; i < 8; i++) s += longint'($signed(din[i]));
        s = s & ((64'sd1 <<< 19) - 1);
      end
      default: begin
        for (int i = 0; i < 5; i++) s += longint'(din[i][7:0]);
        s = s & ((64'sd1 <<< 11) - 1);
      end
    endcase
    return s;
  endfunction

  // One clock: drive, let the edge happen, then update the model for what the edge sampled.
  task automatic cyc(input bit e, input bit v, input bit r);
    exp_t x;
    en  = e;
    vin = v;
    rst = r;
    @(posedge clk);
    last_rst   = r;
    last_stall = !r && !e;
    if (r) begin
      for (int id = 0; id < 3; id++) q[id].delete();
    end else if (e) begin
      en_cnt++;
      if (v) begin
        for (int id = 0; id < 3; id++) begin
          x.val   = model(id);
          x.stamp = en_cnt;
          q[id].push_back(x);
        end
      end
    end
    #1;
  endtask

  task automatic set_all(input logic [15:0] v);
    for (int i = 0; i < 8; i++) din[i] = v;
  endtask

  task automatic mon(input int id, input bit vo, input longint r);
    exp_t x;
    if (last_rst) chk("reset_clear", id, vo == 1'b0 && r == 0, r, 0);
    if (last_stall) begin
      chk("stall_hold_valid", id, vo == pv[id], longint'(vo), longint'(pv[id]));
      chk("stall_hold_result", id, r == pr[id], r, pr[id]);
    end else if (!last_rst) begin
      if (vo) begin
        if (q[id].size() == 0) begin
          chk("spurious_valid", id, 1'b0, r, 0);
        end else begin
          x = q[id].pop_front();
          chk("sum", id, r == x.val, r, x.val);
          chk("latency", id, en_cnt == x.stamp + LEV, longint'(en_cnt),
              longint'(x.stamp + LEV));
        end
      end else if (q[id].size() > 0 && q[id][0].stamp + LEV <= en_cnt) begin
        chk("missing_valid", id, 1'b0, longint'(en_cnt), longint'(q[id][0].stamp + LEV));
        void'(q[id].pop_front());
      end
    end
    pv[id] = vo;
    pr[id] = r;
  endtask

  always @(negedge clk) begin
    if (mon_on) begin
      mon(0, vo_u, longint'(res_u));
      mon(1, vo_s, longint'(res_s));
      mon(2, vo_5, longint'(res_5));
    end
  end

  task automatic rand_in();
    for (int i = 0; i < 8; i++) din[i] = 16'($urandom);
  endtask

  initial begin
    rst = 1'b1;
    en  = 1'b0;
    vin = 1'b0;
    set_all(16'h0000);
    mon_on = 1'b1;
    cyc(1'b0, 1'b0, 1'b1);
    cyc(1'b1, 1'b0, 1'b1);

    // Saturated operands, single-cycle valid.
    set_all(16'hFFFF);
    cyc(1'b1, 1'b1, 1'b0);
    repeat (5) cyc(1'b1, 1'b0, 1'b0);

    // Mixed +1 / -1 operands: zero when signed, 0x40000 when unsigned.
    for (int i = 0; i < 8; i++) din[i] = (i < 4) ? 16'h0001 : 16'hFFFF;
    cyc(1'b1, 1'b1, 1'b0);
    repeat (5) cyc(1'b1, 1'b0, 1'b0);

    // Back-to-back streaming.
    for (int k = 1; k <= 10; k++) begin
      set_all(16'(k));
      cyc(1'b1, 1'b1, 1'b0);
    end
    repeat (5) cyc(1'b1, 1'b0, 1'b0);

    // Two sets in flight, then a 3-cycle stall.
    set_all(16'd100);
    cyc(1'b1, 1'b1, 1'b0);
    set_all(16'd200);
    cyc(1'b1, 1'b1, 1'b0);
    repeat (3) cyc(1'b0, 1'b1, 1'b0);
    repeat (6) cyc(1'b1, 1'b0, 1'b0);

    // Reset with three sets in flight, once with en high and once with en low.
    for (int p = 0; p < 2; p++) begin
      repeat (3) begin
        rand_in();
        cyc(1'b1, 1'b1, 1'b0);
      end
      cyc(p == 0, 1'b0, 1'b1);
      repeat (5) cyc(1'b1, 1'b0, 1'b0);
      rand_in();
      cyc(1'b1, 1'b1, 1'b0);
      repeat (5) cyc(1'b1, 1'b0, 1'b0);
    end

    // Randomized traffic with stalls and rare resets.
    repeat (400) begin
      rand_in();
      cyc($urandom_range(0, 9) < 8, 1'($urandom_range(0, 1)), $urandom_range(0, 99) == 0);
    end

    for (int i = 0; i < 20 && (q[0].size() + q[1].size() + q[2].size()) > 0; i++)
      cyc(1'b1, 1'b0, 1'b0);
    @(negedge clk);
    #1;
    chk("drain_empty", 0, (q[0].size() + q[1].size() + q[2].size()) == 0,
        longint'(q[0].size() + q[1].size() + q[2].size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
